// File: rtl/gnr_node_lut.sv
// gnr_node_lut: one gene-regulatory-network node with a multi-valued state held
// in two independent banks (s0: divided update rate, s1: every step). The next
// state of each bank is read from a runtime-loadable truth table indexed by the
// activity (non-zero state) of N_IN regulator inputs.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   reset_nos           synchronous reload of both banks from init_state
//   init_state          value loaded on reset_nos
//   start_s0, start_s1  per-bank step strobes
//   in_s0, in_s1        regulator states, input i at [i*STATE_W +: STATE_W]
//   cfg_we/addr/data    truth-table write port
//   s0, s1              registered bank states
//   s0_chg, s1_chg      one-cycle pulse after an update that changed the bank
//   trans_cnt           saturating count of s1 changes
//                       (only with GNR_NODE_LUT_TRANS_CNT_EN defined)
//
// Optional feature macro: GNR_NODE_LUT_TRANS_CNT_EN
module gnr_node_lut #(
   parameter int unsigned STATE_W  = 1,
   parameter int unsigned N_IN     = 2,
   parameter int unsigned PASS_DIV = 2,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     reset_nos,
   input  logic [STATE_W-1:0]       init_state,
   input  logic                     start_s0,
   input  logic                     start_s1,
   input  logic [N_IN*STATE_W-1:0]  in_s0,
   input  logic [N_IN*STATE_W-1:0]  in_s1,
   input  logic                     cfg_we,
   input  logic [N_IN-1:0]          cfg_addr,
   input  logic [STATE_W-1:0]       cfg_data,
   output logic [STATE_W-1:0]       s0,
   output logic [STATE_W-1:0]       s1,
   output logic                     s0_chg,
   output logic                     s1_chg
`ifdef GNR_NODE_LUT_TRANS_CNT_EN
   ,
   output logic [CNT_W-1:0]         trans_cnt
`endif
);

   localparam int unsigned DEPTH  = 1 << N_IN;
   localparam int unsigned PCNT_W = (PASS_DIV > 1) ? $clog2(PASS_DIV) : 1;
   localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PASS_DIV - 1);

   // Elaboration-time parameter sanity check
   if (STATE_W < 1 || N_IN < 1 || N_IN > 8 || PASS_DIV < 1 || PASS_DIV > 16 || CNT_W < 1)
   begin : g_param_check
      $error("gnr_node_lut: parameter out of range");
   end

   logic [STATE_W-1:0] lut_q [DEPTH];
   logic [STATE_W-1:0] s0_q, s0_d, s1_q, s1_d;
   logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
   logic               s0_chg_q, s0_chg_d, s1_chg_q, s1_chg_d;
   logic [N_IN-1:0]    idx0, idx1;
   logic [STATE_W-1:0] nxt0, nxt1;

   // Truth-table index: bit i set when regulator i is active (non-zero)
   always_comb begin
      idx0 = '0;
      idx1 = '0;
      for (int i = 0; i < int'(N_IN); i++) begin
         idx0[i] = |in_s0[i*STATE_W +: STATE_W];
         idx1[i] = |in_s1[i*STATE_W +: STATE_W];
      end
   end

   // Lookup reads the registered table, so a same-cycle write is not yet visible
   assign nxt0 = lut_q[idx0];
   assign nxt1 = lut_q[idx1];

   // Truth-table storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) lut_q[i] <= '0;
      end else if (cfg_we) begin
         lut_q[cfg_addr] <= cfg_data;
      end
   end

   // Bank next-state: reload wins over strobes; s0 advances only on the
   // divider's terminal count, so the reload presets it to that count
   always_comb begin
      s0_d     = s0_q;
      s1_d     = s1_q;
      pcnt_d   = pcnt_q;
      s0_chg_d = 1'b0;
      s1_chg_d = 1'b0;
      if (reset_nos) begin
         s0_d   = init_state;
         s1_d   = init_state;
         pcnt_d = PCNT_MAX;
      end else begin
         if (start_s0) begin
            if (pcnt_q == PCNT_MAX) begin
               s0_d     = nxt0;
               pcnt_d   = '0;
               s0_chg_d = (nxt0 != s0_q);
            end else begin
               pcnt_d = pcnt_q + PCNT_W'(1);
            end
         end
         if (start_s1) begin
            s1_d     = nxt1;
            s1_chg_d = (nxt1 != s1_q);
         end
      end
   end

   // Bank state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_q     <= '0;
         s1_q     <= '0;
         pcnt_q   <= '0;
         s0_chg_q <= 1'b0;
         s1_chg_q <= 1'b0;
      end else begin
         s0_q     <= s0_d;
         s1_q     <= s1_d;
         pcnt_q   <= pcnt_d;
         s0_chg_q <= s0_chg_d;
         s1_chg_q <= s1_chg_d;
      end
   end

   assign s0     = s0_q;
   assign s1     = s1_q;
   assign s0_chg = s0_chg_q;
   assign s1_chg = s1_chg_q;

`ifdef GNR_NODE_LUT_TRANS_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturating count of cycles with s1_chg asserted
   always_comb begin
      cnt_d = cnt_q;
      if (reset_nos) begin
         cnt_d = '0;
      end else if (s1_chg_q && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign trans_cnt = cnt_q;
`endif

endmodule
